if_fetch_stage: RTL and testbench
=================================

IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, the PC value loaded by reset.
REQ-002 SHALL have parameter NOP_INSTR, default 16'h0000, the IF_ID_Instr value driven for a bubble.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port PCSrc  in  1  branch redirect request from condition logic.
REQ-006 SHALL have port BranchTarget  in  16  redirect PC.
REQ-007 SHALL have port StallF  in  1  hazard stall: hold PC and IF/ID.
REQ-008 SHALL have port FlushD  in  1  insert a bubble into IF/ID.
REQ-009 SHALL have port imem_req  out  1  fetch request.
REQ-010 SHALL have port imem_addr  out  16  fetch byte address.
REQ-011 SHALL have port imem_ack  in  1  memory ready; transfer occurs when imem_req and imem_ack are both 1.
REQ-012 SHALL have port imem_rdata  in  16  instruction, valid in the transfer cycle.
REQ-013 SHALL have ports IF_ID_Instr  out  16; IF_ID_PC  out  16; IF_ID_Valid  out  1  (IF/ID pipeline register feeding decode).

Function
REQ-014 SHALL keep a 16-bit PC, drive imem_addr = PC, and advance PC by 2 per accepted transfer, wrapping 16'hFFFE -> 16'h0000.
REQ-015 SHALL implement an FSM with states BOOT, FETCH, HOLD.
REQ-016 SHALL spend exactly one cycle in BOOT after reset release with imem_req=0, then enter FETCH.
REQ-017 SHALL, in FETCH, assert imem_req when StallF=0, FlushD=0, PCSrc=0, and hold imem_addr stable until transfer.
REQ-018 SHALL, on transfer, load IF_ID_Instr=imem_rdata, IF_ID_PC=PC, IF_ID_Valid=1 at the same edge; zero-wait memory yields 1 instruction/cycle.
REQ-019 SHALL, when FETCH with no transfer, set IF_ID_Valid=0 and IF_ID_Instr=NOP_INSTR (bubble).
REQ-020 SHALL, when StallF=1, move to HOLD, deassert imem_req, and hold PC, IF_ID_* unchanged; it returns to FETCH the cycle after StallF=0.
REQ-021 SHALL, when PCSrc=1, load PC = {BranchTarget[15:1],1'b0}, flush IF/ID to bubble, deassert imem_req that cycle, and enter FETCH.
REQ-022 SHALL, when FlushD=1 with PCSrc=0, flush IF/ID to bubble, deassert imem_req, and hold PC.
REQ-023 SHALL apply priority reset > PCSrc > FlushD > StallF > fetch on simultaneous events.
REQ-024 SHALL ignore imem_ack and imem_rdata whenever imem_req=0.

Reset
REQ-025 SHALL, on reset=0 at any time, asynchronously set PC=RESET_PC, state=BOOT, IF_ID_Instr=NOP_INSTR, IF_ID_PC=16'h0000, IF_ID_Valid=0, imem_req=0, and clear the skid buffer if present.
REQ-026 SHALL abandon any pending fetch on reset mid-operation; no transfer completes while reset=0.

Configuration
REQ-027 SHALL compile a one-entry skid buffer only when macro IF_SKID_BUF_EN is defined.
REQ-028 SHALL, with IF_SKID_BUF_EN, keep fetching while StallF=1 until the buffer is full, capture that instruction and its PC, advance PC, and load IF/ID from the buffer on the first unstalled cycle; no fetch is issued that cycle.
REQ-029 SHALL, with IF_SKID_BUF_EN, discard the buffer on PCSrc=1 or FlushD=1.
REQ-030 SHALL, without IF_SKID_BUF_EN, behave exactly as REQ-020, with no fetch during stall.

Verification
REQ-031 SHALL cover: reset release, imem_ack=1 constant, rdata=16'h1111,16'h2222 -> first imem_req after BOOT at addr 0000; IF_ID_PC 0000, 0002; Valid=1 on consecutive edges.
REQ-032 SHALL cover: imem_ack low 3 cycles at addr 0004 -> imem_addr stays 0004, 3 bubbles, then Instr=rdata with IF_ID_PC=0004.
REQ-033 SHALL cover: StallF=1 for 2 cycles with IF_ID_PC=0006 -> IF/ID and PC unchanged. Without the macro, imem_req=0. With IF_SKID_BUF_EN, one fetch at 0008 is buffered and appears in IF/ID after release.
REQ-034 SHALL cover: PCSrc=1, BranchTarget=16'h0041, StallF=1 the same cycle -> PC=0040, bubble in IF/ID, next fetch at 0040.
REQ-035 SHALL cover: PC=FFFE fetch -> next imem_addr 0000; reset pulse low mid-wait -> immediate bubble, PC=RESET_PC.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC, fetch handshake and the IF/ID pipeline register.
// Defining IF_SKID_BUF_EN adds a one-entry skid buffer that keeps fetching through a stall.
module if_fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PCSrc,
    input  logic [15:0] BranchTarget,
    input  logic        StallF,
    input  logic        FlushD,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic [15:0] IF_ID_Instr,
    output logic [15:0] IF_ID_PC,
    output logic        IF_ID_Valid
);

    typedef enum logic [1:0] {BOOT, FETCH, HOLD} state_t;

    state_t      state;
    logic [15:0] pc;
    logic        xfer;

    assign imem_addr = pc;
    assign xfer      = imem_req && imem_ack;

`ifdef IF_SKID_BUF_EN
    logic        buf_vld;
    logic [15:0] buf_instr;
    logic [15:0] buf_pc;

    // While stalled, keep one fetch in flight until the buffer holds an instruction.
    always_comb begin
        imem_req = 1'b0;
        if (!PCSrc && !FlushD) begin
            if (state == FETCH)
                imem_req = !StallF || !buf_vld;
            else if (state == HOLD)
                imem_req = StallF && !buf_vld;
        end
    end
`else
    assign imem_req = (state == FETCH) && !StallF && !FlushD && !PCSrc;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            IF_ID_Instr <= NOP_INSTR;
            IF_ID_PC    <= 16'h0000;
            IF_ID_Valid <= 1'b0;
`ifdef IF_SKID_BUF_EN
            buf_vld     <= 1'b0;
            buf_instr   <= NOP_INSTR;
            buf_pc      <= 16'h0000;
`endif
        end else if (PCSrc) begin
            pc          <= BranchTarget & 16'hFFFE;
            IF_ID_Instr <= NOP_INSTR;
            IF_ID_Valid <= 1'b0;
            state       <= FETCH;
`ifdef IF_SKID_BUF_EN
            buf_vld     <= 1'b0;
`endif
        end else if (FlushD) begin
            IF_ID_Instr <= NOP_INSTR;
            IF_ID_Valid <= 1'b0;
            state       <= (state != BOOT && StallF) ? HOLD : FETCH;
`ifdef IF_SKID_BUF_EN
            buf_vld     <= 1'b0;
`endif
        end else if (state == BOOT) begin
            state <= FETCH;
        end else if (StallF) begin
            state <= HOLD;
`ifdef IF_SKID_BUF_EN
            if (xfer) begin
                buf_vld   <= 1'b1;
                buf_instr <= imem_rdata;
                buf_pc    <= pc;
                pc        <= pc + 16'd2;
            end
`endif
        end else if (state == HOLD) begin
            // Release cycle: decode consumes the held entry, so replace it (no fetch here).
            state <= FETCH;
`ifdef IF_SKID_BUF_EN
            IF_ID_Instr <= buf_vld ? buf_instr : NOP_INSTR;
            IF_ID_Valid <= buf_vld;
            if (buf_vld)
                IF_ID_PC <= buf_pc;
            buf_vld <= 1'b0;
`else
            IF_ID_Instr <= NOP_INSTR;
            IF_ID_Valid <= 1'b0;
`endif
        end else if (xfer) begin
            IF_ID_Instr <= imem_rdata;
            IF_ID_PC    <= pc;
            IF_ID_Valid <= 1'b1;
            pc          <= pc + 16'd2;
        end else begin
            IF_ID_Instr <= NOP_INSTR;
            IF_ID_Valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: per-cycle compare against a behavioural model plus literal spot checks.
module tb_if_fetch_stage;

    localparam logic [15:0] RST_PC = 16'h0000;
    localparam logic [15:0] NOP    = 16'h0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        PCSrc = 1'b0;
    logic [15:0] BranchTarget = 16'h0000;
    logic        StallF = 1'b0;
    logic        FlushD = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b1;
    logic [15:0] imem_rdata = 16'h0000;
    logic [15:0] IF_ID_Instr;
    logic [15:0] IF_ID_PC;
    logic        IF_ID_Valid;

    int n_chk  = 0;
    int n_fail = 0;
    logic chk_en = 1'b0;

    if_fetch_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .clk(clk), .reset(reset), .PCSrc(PCSrc), .BranchTarget(BranchTarget),
        .StallF(StallF), .FlushD(FlushD), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .IF_ID_Instr(IF_ID_Instr),
        .IF_ID_PC(IF_ID_PC), .IF_ID_Valid(IF_ID_Valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: what the stage must present, derived from the fetch rules.
    logic [15:0] m_pc    = RST_PC;
    logic [15:0] m_instr = NOP;
    logic [15:0] m_ifpc  = 16'h0000;
    logic        m_valid = 1'b0;
    logic        m_boot  = 1'b1;   // first cycle after reset release
    logic        m_held  = 1'b0;   // a stall has been taken and not yet released
    logic        m_xf;
`ifdef IF_SKID_BUF_EN
    logic [31:0] m_q[$];
`endif

    function automatic logic model_req();
        if (m_boot || PCSrc || FlushD) return 1'b0;
`ifdef IF_SKID_BUF_EN
        if (StallF) return m_q.size() == 0;
        return !m_held;
`else
        return !StallF && !m_held;
`endif
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_pc = RST_PC; m_instr = NOP; m_ifpc = 16'h0000; m_valid = 1'b0;
            m_boot = 1'b1; m_held = 1'b0;
`ifdef IF_SKID_BUF_EN
            m_q.delete();
`endif
        end else begin
            m_xf = model_req() && imem_ack;
            if (PCSrc) begin
                m_pc = {BranchTarget[15:1], 1'b0};
                m_instr = NOP; m_valid = 1'b0; m_boot = 1'b0; m_held = 1'b0;
`ifdef IF_SKID_BUF_EN
                m_q.delete();
`endif
            end else if (FlushD) begin
                m_instr = NOP; m_valid = 1'b0;
                m_held = !m_boot && StallF; m_boot = 1'b0;
`ifdef IF_SKID_BUF_EN
                m_q.delete();
`endif
            end else if (m_boot) begin
                m_boot = 1'b0;
            end else if (StallF) begin
                m_held = 1'b1;
`ifdef IF_SKID_BUF_EN
                if (m_xf) begin m_q.push_back({m_pc, imem_rdata}); m_pc = m_pc + 16'd2; end
`endif
            end else if (m_held) begin
                m_held = 1'b0; m_instr = NOP; m_valid = 1'b0;
`ifdef IF_SKID_BUF_EN
                if (m_q.size() != 0) begin
                    m_ifpc = m_q[0][31:16]; m_instr = m_q[0][15:0]; m_valid = 1'b1;
                    m_q.delete();
                end
`endif
            end else if (m_xf) begin
                m_instr = imem_rdata; m_ifpc = m_pc; m_valid = 1'b1; m_pc = m_pc + 16'd2;
            end else begin
                m_instr = NOP; m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("imem_req", 16'(imem_req), 16'(reset ? model_req() : 1'b0));
            chk("imem_addr", imem_addr, m_pc);
            chk("IF_ID_Valid", 16'(IF_ID_Valid), 16'(m_valid));
            chk("IF_ID_Instr", IF_ID_Instr, m_instr);
            if (m_valid) chk("IF_ID_PC", IF_ID_PC, m_ifpc);
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        step(); step();
        chk("rst_req", 16'(imem_req), 16'h0);
        chk("rst_addr", imem_addr, 16'h0000);
        chk("rst_valid", 16'(IF_ID_Valid), 16'h0);
        chk("rst_instr", IF_ID_Instr, 16'h0000);
        chk("rst_ifpc", IF_ID_PC, 16'h0000);
        chk_en = 1'b1;
        reset = 1'b1;
        #1 chk("boot_req", 16'(imem_req), 16'h0);
        step();
        imem_rdata = 16'h1111;
        #1 chk("first_req", 16'(imem_req), 16'h1);
        chk("first_addr", imem_addr, 16'h0000);
        step();
        chk("f1_instr", IF_ID_Instr, 16'h1111);
        chk("f1_pc", IF_ID_PC, 16'h0000);
        chk("f1_valid", 16'(IF_ID_Valid), 16'h1);
        imem_rdata = 16'h2222;
        step();
        chk("f2_instr", IF_ID_Instr, 16'h2222);
        chk("f2_pc", IF_ID_PC, 16'h0002);
        chk("f2_valid", 16'(IF_ID_Valid), 16'h1);
        // memory wait states at 0004
        imem_ack = 1'b0; imem_rdata = 16'hDEAD;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("wait_addr", imem_addr, 16'h0004);
            chk("wait_valid", 16'(IF_ID_Valid), 16'h0);
        end
        imem_ack = 1'b1; imem_rdata = 16'h3333;
        step();
        chk("w_instr", IF_ID_Instr, 16'h3333);
        chk("w_pc", IF_ID_PC, 16'h0004);
        imem_rdata = 16'h4444;
        step();
        // two-cycle stall holding IF_ID_PC=0006
        StallF = 1'b1; imem_rdata = 16'h5555;
`ifdef IF_SKID_BUF_EN
        #1 chk("stall_req", 16'(imem_req), 16'h1);
`else
        #1 chk("stall_req", 16'(imem_req), 16'h0);
`endif
        step(); step();
        chk("stall_ifpc", IF_ID_PC, 16'h0006);
        chk("stall_instr", IF_ID_Instr, 16'h4444);
`ifdef IF_SKID_BUF_EN
        chk("stall_addr", imem_addr, 16'h000A);
`else
        chk("stall_addr", imem_addr, 16'h0008);
`endif
        StallF = 1'b0;
        step();
`ifdef IF_SKID_BUF_EN
        chk("skid_instr", IF_ID_Instr, 16'h5555);
        chk("skid_pc", IF_ID_PC, 16'h0008);
`else
        chk("rel_valid", 16'(IF_ID_Valid), 16'h0);
        step();
        chk("post_instr", IF_ID_Instr, 16'h5555);
        chk("post_pc", IF_ID_PC, 16'h0008);
`endif
        // branch beats a simultaneous stall
        PCSrc = 1'b1; BranchTarget = 16'h0041; StallF = 1'b1; imem_rdata = 16'hBAD0;
        #1 chk("br_req", 16'(imem_req), 16'h0);
        step();
        chk("br_addr", imem_addr, 16'h0040);
        chk("br_valid", 16'(IF_ID_Valid), 16'h0);
        PCSrc = 1'b0; StallF = 1'b0; imem_rdata = 16'h6666;
        #1 chk("br_fetch_req", 16'(imem_req), 16'h1);
        step();
        chk("br_instr", IF_ID_Instr, 16'h6666);
        chk("br_ifpc", IF_ID_PC, 16'h0040);
        // flush beats stall, PC held
        FlushD = 1'b1; StallF = 1'b1; imem_rdata = 16'hBAD1;
        step();
        chk("fl_valid", 16'(IF_ID_Valid), 16'h0);
        chk("fl_addr", imem_addr, 16'h0042);
        FlushD = 1'b0; StallF = 1'b0;
        step();
        // branch beats flush, odd target aligned, then wrap
        PCSrc = 1'b1; FlushD = 1'b1; BranchTarget = 16'hFFFF;
        step();
        chk("wrap_addr0", imem_addr, 16'hFFFE);
        PCSrc = 1'b0; FlushD = 1'b0; imem_rdata = 16'h7777;
        step();
        chk("wrap_instr", IF_ID_Instr, 16'h7777);
        chk("wrap_ifpc", IF_ID_PC, 16'hFFFE);
        chk("wrap_addr", imem_addr, 16'h0000);
        // reset pulse in the middle of a wait
        imem_ack = 1'b0;
        #2 reset = 1'b0;
        #1 chk("ar_valid", 16'(IF_ID_Valid), 16'h0);
        chk("ar_instr", IF_ID_Instr, NOP);
        chk("ar_addr", imem_addr, RST_PC);
        chk("ar_req", 16'(imem_req), 16'h0);
        step();
        reset = 1'b1; imem_ack = 1'b1; imem_rdata = 16'h8888;
        step();
        step();
        chk("rr_instr", IF_ID_Instr, 16'h8888);
        chk("rr_ifpc", IF_ID_PC, 16'h0000);
        for (int i = 0; i < 6; i++) begin
            imem_ack = (i % 3) != 1;
            imem_rdata = 16'hA000 + 16'(i);
            step();
        end
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
